pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//   Central stall/flush sequencer for the 5-stage pipeline. It drives the stall/nop pairs of the
//   IF/ID, ID/EX, EX/MEM and MEM/WB buffers and the PC hold. Its inputs are cache handshakes,
//   load-use detection, the EX redirect pulse and the multicycle mul/div unit.
//   Buffer contract: stall=1 holds the buffer and overrides nop; nop=1 with stall=0 loads a bubble.
// PARAMETERS
//   CNT_W  32  width of the saturating performance counters
// PORTS
//   clk            in   1      rising-edge clock
//   rst            in   1      reset: synchronous, active-low (0 = reset)
//   imem_read      in   1      I-cache request outstanding
//   imem_resp      in   1      I-cache response this cycle
//   dmem_read      in   1      D-cache read in MEM
//   dmem_write     in   1      D-cache write in MEM
//   dmem_resp      in   1      D-cache response this cycle
//   ex_is_load     in   1      instruction in EX is a load
//   ex_rd          in   5      EX destination register
//   id_rs1         in   5      ID source register 1
//   id_rs2         in   5      ID source register 2
//   id_uses_rs1    in   1      ID instruction reads rs1
//   id_uses_rs2    in   1      ID instruction reads rs2
//   ex_redirect    in   1      one-cycle pulse: EX mispredict/jump, younger instructions invalid
//   muldiv_start   in   1      EX issues a mul/div this cycle
//   muldiv_done    in   1      mul/div result valid this cycle
//   pc_stall       out  1      hold PC
//   if_id_stall    out  1      IF/ID buffer hold
//   if_id_nop      out  1      IF/ID buffer bubble
//   id_ex_stall    out  1      ID/EX buffer hold
//   id_ex_nop      out  1      ID/EX buffer bubble
//   ex_mem_stall   out  1      EX/MEM buffer hold
//   ex_mem_nop     out  1      EX/MEM buffer bubble
//   mem_wb_stall   out  1      MEM/WB buffer hold
//   mem_wb_nop     out  1      MEM/WB buffer bubble
//   state_o        out  2      FSM state: 0=RUN, 1=MULDIV, 2=FLUSH_PEND
//   stall_cycles   out  CNT_W  count of cycles with pc_stall=1; saturates
//   flush_count    out  CNT_W  count of applied flushes; saturates
// BEHAVIOUR
//   Combinational terms:
//     mem_busy = (dmem_read|dmem_write)&~dmem_resp
//     if_busy  = imem_read&~imem_resp
//     gstall   = mem_busy|if_busy
//     lu = ex_is_load & ex_rd!=0 & ((id_uses_rs1&id_rs1==ex_rd)|(id_uses_rs2&id_rs2==ex_rd))
//   Reset: while rst=0, all *_stall=0 and all *_nop=1.
//     At the clock edge: state<=RUN, flush pending cleared, both counters<=0.
//     Reset mid-MULDIV or mid-FLUSH_PEND aborts to RUN with no residue.
//   Outputs are combinational from state+inputs, zero latency. Registered: state, counters.
//   Priority: gstall > flush (redirect or pending) > MULDIV hold > load-use.
//   gstall=1 (any state): all four stalls=1, pc_stall=1, all nops=0.
//     An ex_redirect in this cycle -> next state FLUSH_PEND.
//     An ex_redirect is never lost.
//   RUN, no gstall:
//     ex_redirect=1: if_id_nop=1, id_ex_nop=1, other outputs 0, flush_count++.
//       ex_redirect overrides lu and muldiv_start.
//     else muldiv_start=1: next state MULDIV. Outputs this cycle as for normal flow.
//     else lu=1: pc_stall=1, if_id_stall=1, id_ex_nop=1, one bubble.
//       Releases automatically next cycle because the load moves to MEM.
//     else: all outputs 0.
//   MULDIV, no gstall:
//     muldiv_done=0: pc/if_id/id_ex stall=1, ex_mem_nop=1. Bubbles flow into MEM.
//     muldiv_done=1: all stalls 0 (ID/EX advances), next state RUN.
//     An ex_redirect in MULDIV is treated as in RUN and also returns the FSM to RUN.
//   FLUSH_PEND, no gstall: apply the flush outputs as for ex_redirect, flush_count++, next state RUN.
//     A further ex_redirect while pending merges into the single pending flush.
//   Counters: +1 per qualifying cycle; hold at 2^CNT_W-1.
// TESTING
//   1. Load-use. ex_is_load=1, ex_rd=5, id_rs2=5, id_uses_rs2=1, no busy.
//      -> pc_stall=if_id_stall=id_ex_nop=1 for exactly 1 cycle; stall_cycles=1.
//   2. Redirect beats load-use. Same as test 1 plus ex_redirect=1.
//      -> if_id_nop=id_ex_nop=1, pc_stall=0, flush_count=1.
//   3. D-cache miss. dmem_read=1 with dmem_resp low 4 cycles; ex_redirect pulsed in cycle 2.
//      -> all stalls=1 for 4 cycles, state_o=2.
//      -> on the dmem_resp cycle +1: single flush, state_o=0, flush_count=1.
//   4. Mul/div. muldiv_start, then muldiv_done 6 cycles later.
//      -> state_o=1 for 6 cycles, ex_mem_nop=1 each cycle, stalls drop on the done cycle.
//   5. Reset mid-MULDIV. Drive rst=0 during cycle 3 of test 4.
//      -> next state_o=0, counters=0; during reset stalls=0 and nops=1.
//   6. Saturation. CNT_W=4 with a held imem miss for 20 cycles -> stall_cycles stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives per-buffer stall/nop pairs and PC hold,
// tracks multicycle mul/div and deferred flushes, and keeps saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic             dmem_resp,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_redirect,
  input  logic             muldiv_start,
  input  logic             muldiv_done,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_nop,
  output logic             id_ex_stall,
  output logic             id_ex_nop,
  output logic             ex_mem_stall,
  output logic             ex_mem_nop,
  output logic             mem_wb_stall,
  output logic             mem_wb_nop,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN = 2'd0, MULDIV = 2'd1, FLUSH_PEND = 2'd2} state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_stall_cycles, r_flush_count;
  logic             w_mem_busy, w_if_busy, w_gstall, w_lu, w_flush;

  assign w_mem_busy = (dmem_read | dmem_write) & ~dmem_resp;
  assign w_if_busy  = imem_read & ~imem_resp;
  assign w_gstall   = w_mem_busy | w_if_busy;
  assign w_lu       = ex_is_load && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_nop    = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_nop    = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_nop   = 1'b0;
    mem_wb_stall = 1'b0;
    mem_wb_nop   = 1'b0;
    w_flush      = 1'b0;
    w_next       = r_state;
    if (!rst) begin
      if_id_nop  = 1'b1;
      id_ex_nop  = 1'b1;
      ex_mem_nop = 1'b1;
      mem_wb_nop = 1'b1;
      w_next     = RUN;
    end else if (w_gstall) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_stall = 1'b1;
      // Redirect arriving while frozen is parked until the pipe moves again
      if (ex_redirect) w_next = FLUSH_PEND;
    end else if (ex_redirect || (r_state == FLUSH_PEND)) begin
      if_id_nop = 1'b1;
      id_ex_nop = 1'b1;
      w_flush   = 1'b1;
      w_next    = RUN;
    end else begin
      case (r_state)
        MULDIV: begin
          if (!muldiv_done) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            ex_mem_nop  = 1'b1;
          end else begin
            w_next = RUN;
          end
        end
        default: begin
          if (muldiv_start) begin
            w_next = MULDIV;
          end else if (w_lu) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_nop   = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= RUN;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state <= w_next;
      if (pc_stall && (r_stall_cycles != {CNT_W{1'b1}})) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_flush && (r_flush_count != {CNT_W{1'b1}}))   r_flush_count  <= r_flush_count + 1'b1;
    end
  end

  assign state_o      = r_state;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: single-cycle vector table from RUN plus
// multi-cycle sequences for cache miss, mul/div, reset abort and counter saturation.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_read, imem_resp, dmem_read, dmem_write, dmem_resp, ex_is_load;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic       id_uses_rs1, id_uses_rs2, ex_redirect, muldiv_start, muldiv_done;

  logic        pc_stall, if_id_stall, if_id_nop, id_ex_stall, id_ex_nop;
  logic        ex_mem_stall, ex_mem_nop, mem_wb_stall, mem_wb_nop;
  logic [1:0]  state_o;
  logic [31:0] stall_cycles, flush_count;

  logic        pc_stall4, if_id_stall4, if_id_nop4, id_ex_stall4, id_ex_nop4;
  logic        ex_mem_stall4, ex_mem_nop4, mem_wb_stall4, mem_wb_nop4;
  logic [1:0]  state_o4;
  logic [3:0]  stall_cycles4, flush_count4;

  int total = 0;
  int bad   = 0;

  // {pc, if_id_stall, if_id_nop, id_ex_stall, id_ex_nop, ex_mem_stall, ex_mem_nop, mem_wb_stall, mem_wb_nop}
  localparam logic [8:0] O_ZERO  = 9'b000000000;
  localparam logic [8:0] O_RST   = 9'b001010101;
  localparam logic [8:0] O_GST   = 9'b110101010;
  localparam logic [8:0] O_FLUSH = 9'b001010000;
  localparam logic [8:0] O_LU    = 9'b110010000;
  localparam logic [8:0] O_MD    = 9'b110100100;

  logic [8:0] w_out, w_out4;
  assign w_out  = {pc_stall, if_id_stall, if_id_nop, id_ex_stall, id_ex_nop,
                   ex_mem_stall, ex_mem_nop, mem_wb_stall, mem_wb_nop};
  assign w_out4 = {pc_stall4, if_id_stall4, if_id_nop4, id_ex_stall4, id_ex_nop4,
                   ex_mem_stall4, ex_mem_nop4, mem_wb_stall4, mem_wb_nop4};

  pipeline_hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_redirect(ex_redirect), .muldiv_start(muldiv_start), .muldiv_done(muldiv_done),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_nop(if_id_nop),
    .id_ex_stall(id_ex_stall), .id_ex_nop(id_ex_nop),
    .ex_mem_stall(ex_mem_stall), .ex_mem_nop(ex_mem_nop),
    .mem_wb_stall(mem_wb_stall), .mem_wb_nop(mem_wb_nop),
    .state_o(state_o), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_redirect(ex_redirect), .muldiv_start(muldiv_start), .muldiv_done(muldiv_done),
    .pc_stall(pc_stall4), .if_id_stall(if_id_stall4), .if_id_nop(if_id_nop4),
    .id_ex_stall(id_ex_stall4), .id_ex_nop(id_ex_nop4),
    .ex_mem_stall(ex_mem_stall4), .ex_mem_nop(ex_mem_nop4),
    .mem_wb_stall(mem_wb_stall4), .mem_wb_nop(mem_wb_nop4),
    .state_o(state_o4), .stall_cycles(stall_cycles4), .flush_count(flush_count4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ir, irsp, dr, dw, drsp, ld;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, red, ms, md;
    logic [8:0] exp_out;
    logic [1:0] exp_st;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(logic ir, logic irsp, logic dr, logic dw, logic drsp, logic ld,
                              logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic u1, logic u2, logic red, logic ms, logic md,
                              logic [8:0] eo, logic [1:0] es);
    vec_t v;
    v.ir = ir; v.irsp = irsp; v.dr = dr; v.dw = dw; v.drsp = drsp; v.ld = ld;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.red = red; v.ms = ms; v.md = md; v.exp_out = eo; v.exp_st = es;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    imem_read = 0; imem_resp = 0; dmem_read = 0; dmem_write = 0; dmem_resp = 0;
    ex_is_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_redirect = 0; muldiv_start = 0; muldiv_done = 0;
  endtask

  task automatic apply(input vec_t v);
    imem_read = v.ir; imem_resp = v.irsp; dmem_read = v.dr; dmem_write = v.dw;
    dmem_resp = v.drsp; ex_is_load = v.ld; ex_rd = v.rd; id_rs1 = v.rs1; id_rs2 = v.rs2;
    id_uses_rs1 = v.u1; id_uses_rs2 = v.u2; ex_redirect = v.red;
    muldiv_start = v.ms; muldiv_done = v.md;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Ends at a negedge with reset released and inputs idle
  task automatic do_reset();
    rst = 0;
    clr();
    tick();
    rst = 1;
  endtask

  task automatic set_lu();
    ex_is_load = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1;
  endtask

  initial begin
    //          ir irs dr dw drs ld rd     rs1    rs2    u1 u2 red ms md  out      st
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0, O_ZERO,  2'd0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 1, 5'd5,  5'd0,  5'd5,  0, 1, 0, 0, 0, O_LU,    2'd0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 1, 5'd7,  5'd7,  5'd0,  0, 1, 0, 0, 0, O_ZERO,  2'd0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 1, 5'd0,  5'd0,  5'd0,  1, 1, 0, 0, 0, O_ZERO,  2'd0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 1, 5'd5,  5'd0,  5'd5,  0, 1, 1, 0, 0, O_FLUSH, 2'd0);
    tbl[5]  = mk(1, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0, O_GST,   2'd0);
    tbl[6]  = mk(1, 1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0, O_ZERO,  2'd0);
    tbl[7]  = mk(0, 0, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 1, 0, 0, O_GST,   2'd2);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 1, 0, O_ZERO,  2'd1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 1, 5'd3,  5'd3,  5'd0,  1, 0, 0, 1, 0, O_ZERO,  2'd1);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 1, 1, 0, O_FLUSH, 2'd0);
    tbl[11] = mk(0, 0, 0, 0, 0, 1, 5'd31, 5'd31, 5'd2,  1, 0, 0, 0, 0, O_LU,    2'd0);

    clr();
    rst = 0;
    @(negedge clk);
    #1 chk("reset_outs", {23'd0, w_out}, {23'd0, O_RST});
    tick();
    chk("reset_state", {30'd0, state_o}, 32'd0);
    chk("reset_stallcnt", stall_cycles, 32'd0);
    chk("reset_flushcnt", flush_count, 32'd0);
    rst = 1;

    for (int i = 0; i < 12; i++) begin
      do_reset();
      apply(tbl[i]);
      #1 chk($sformatf("vec%0d_outs", i), {23'd0, w_out}, {23'd0, tbl[i].exp_out});
      tick();
      chk($sformatf("vec%0d_next", i), {30'd0, state_o}, {30'd0, tbl[i].exp_st});
    end

    // Load-use holds exactly one cycle
    do_reset();
    set_lu();
    #1 chk("lu_stall", {23'd0, w_out}, {23'd0, O_LU});
    tick();
    clr();
    #1 chk("lu_release", {23'd0, w_out}, {23'd0, O_ZERO});
    chk("lu_stallcnt", stall_cycles, 32'd1);

    // Redirect beats load-use
    do_reset();
    set_lu();
    ex_redirect = 1;
    #1 chk("redir_lu_outs", {23'd0, w_out}, {23'd0, O_FLUSH});
    tick();
    clr();
    #1 chk("redir_lu_flushcnt", flush_count, 32'd1);
    chk("redir_lu_stallcnt", stall_cycles, 32'd0);

    // D-cache miss with redirect parked until the response
    do_reset();
    dmem_read = 1;
    for (int c = 0; c < 4; c++) begin
      ex_redirect = (c == 1);
      #1 chk($sformatf("dmiss_c%0d_outs", c), {23'd0, w_out}, {23'd0, O_GST});
      chk($sformatf("dmiss_c%0d_state", c), {30'd0, state_o}, (c >= 2) ? 32'd2 : 32'd0);
      tick();
    end
    ex_redirect = 0;
    dmem_resp = 1;
    #1 chk("dmiss_resp_outs", {23'd0, w_out}, {23'd0, O_FLUSH});
    chk("dmiss_resp_state", {30'd0, state_o}, 32'd2);
    tick();
    clr();
    #1 chk("dmiss_after_state", {30'd0, state_o}, 32'd0);
    chk("dmiss_after_outs", {23'd0, w_out}, {23'd0, O_ZERO});
    chk("dmiss_flushcnt", flush_count, 32'd1);
    chk("dmiss_stallcnt", stall_cycles, 32'd4);

    // Mul/div: done arrives 6 cycles after start
    do_reset();
    muldiv_start = 1;
    #1 chk("md_start_outs", {23'd0, w_out}, {23'd0, O_ZERO});
    tick();
    muldiv_start = 0;
    for (int c = 1; c <= 6; c++) begin
      muldiv_done = (c == 6);
      #1 chk($sformatf("md_c%0d_state", c), {30'd0, state_o}, 32'd1);
      chk($sformatf("md_c%0d_outs", c), {23'd0, w_out}, {23'd0, (c < 6) ? O_MD : O_ZERO});
      tick();
    end
    muldiv_done = 0;
    #1 chk("md_end_state", {30'd0, state_o}, 32'd0);
    chk("md_stallcnt", stall_cycles, 32'd5);

    // Reset in the third mul/div cycle aborts to RUN
    do_reset();
    muldiv_start = 1;
    tick();
    muldiv_start = 0;
    tick();
    tick();
    #1 chk("mdrst_pre_state", {30'd0, state_o}, 32'd1);
    chk("mdrst_pre_stallcnt", stall_cycles, 32'd2);
    rst = 0;
    #1 chk("mdrst_outs", {23'd0, w_out}, {23'd0, O_RST});
    tick();
    rst = 1;
    #1 chk("mdrst_state", {30'd0, state_o}, 32'd0);
    chk("mdrst_stallcnt", stall_cycles, 32'd0);
    chk("mdrst_flushcnt", flush_count, 32'd0);
    chk("mdrst_outs_after", {23'd0, w_out}, {23'd0, O_ZERO});

    // Saturation on the 4-bit instance under a held I-cache miss
    do_reset();
    imem_read = 1;
    for (int i = 1; i <= 20; i++) begin
      #1 chk($sformatf("sat_i%0d_outs4", i), {23'd0, w_out4}, {23'd0, O_GST});
      tick();
      chk($sformatf("sat_i%0d_cnt4", i), {28'd0, stall_cycles4}, (i < 15) ? i : 15);
      chk($sformatf("sat_i%0d_cnt32", i), stall_cycles, i);
    end
    chk("sat_state4", {30'd0, state_o4}, 32'd0);
    chk("sat_flushcnt4", {28'd0, flush_count4}, 32'd0);
    clr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
